ca_prng_stream: RTL and testbench

//  Parametrised cellular-automaton random word source: a 1D wrap-around elementary CA of
//  CA_WIDTH cells, parity-folded to WIDTH output bits, with selectable rule mode.

---
 rtl/ca_prng_stream.sv | 193 +++++++++++++++++++
 tb/tb_ca_prng_stream.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ca_prng_stream.sv
// Elementary cellular-automaton random word source with reseed, warm-up, zero guard and valid/ready output.
// Optional CA_PRNG_HEALTH_EN adds a sticky health_fail flag for 4 equal consecutive delivered words.
module ca_prng_stream #(
  parameter int unsigned         WIDTH        = 32,
  parameter int unsigned         PARITY_WIDTH = 3,
  parameter int unsigned         CA_WIDTH     = WIDTH * PARITY_WIDTH,
  parameter logic [CA_WIDTH-1:0] SEED         = CA_WIDTH'(1) << (CA_WIDTH / 2),
  parameter int unsigned         WARMUP       = 16,
  parameter int unsigned         RULE_SHIFT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [1:0]       mode,
  input  logic [7:0]       rule_in,
  input  logic             seed_valid,
  input  logic [WIDTH-1:0] seed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef CA_PRNG_HEALTH_EN
  output logic             health_fail,
`endif
  output logic             busy
);

  localparam int unsigned STEP_W = 16;
  localparam int unsigned WARM_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

  typedef enum logic {ST_WARMUP, ST_RUN} state_e;
  localparam state_e ST_INIT = (WARMUP == 0) ? ST_RUN : ST_WARMUP;

  state_e              state_q, state_d;
  logic [CA_WIDTH-1:0] s_q, s_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [WARM_W-1:0]   warm_q, warm_d;
  logic                valid_q, valid_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                busy_q, busy_d;

  logic [7:0]          rule;
  logic [CA_WIDTH-1:0] s_step;
  logic [CA_WIDTH-1:0] s_seed;

  // One wrap-around CA step; an all-zero result would lock up, so it falls back to SEED.
  function automatic logic [CA_WIDTH-1:0] ca_next(input logic [CA_WIDTH-1:0] s,
                                                  input logic [7:0]          r);
    logic [CA_WIDTH-1:0] lft;
    logic [CA_WIDTH-1:0] rgt;
    logic [CA_WIDTH-1:0] n;
    lft = {s[0], s[CA_WIDTH-1:1]};
    rgt = {s[CA_WIDTH-2:0], s[CA_WIDTH-1]};
    n   = '0;
    for (int unsigned i = 0; i < CA_WIDTH; i++) begin
      n[i] = r[{lft[i], s[i], rgt[i]}];
    end
    return (n == '0) ? SEED : n;
  endfunction

  function automatic logic [WIDTH-1:0] fold_word(input logic [CA_WIDTH-1:0] s);
    logic [WIDTH-1:0]        o;
    logic [PARITY_WIDTH-1:0] g;
    o = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      g    = s[i*PARITY_WIDTH +: PARITY_WIDTH];
      o[i] = i[0] ? ^g : ~^g;
    end
    return o;
  endfunction

  always_comb begin
    rule = 8'h96;
    unique case (mode)
      2'd0: rule = 8'h1E;
      2'd1: begin
        unique case (step_q[RULE_SHIFT+1:RULE_SHIFT])
          2'd0:    rule = 8'h1E;
          2'd1:    rule = 8'h3C;
          2'd2:    rule = 8'h5A;
          default: rule = 8'h96;
        endcase
      end
      2'd2:    rule = rule_in;
      default: rule = 8'h96;
    endcase
  end

  assign s_step = ca_next(s_q, rule);
  assign s_seed = ({PARITY_WIDTH{seed}} ^ SEED) == '0 ? SEED : ({PARITY_WIDTH{seed}} ^ SEED);

  // Reseed overrides everything, including a held word and ce.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    step_d  = step_q;
    warm_d  = warm_q;
    valid_d = valid_q;
    data_d  = data_q;
    if (seed_valid) begin
      s_d     = s_seed;
      step_d  = '0;
      warm_d  = '0;
      valid_d = 1'b0;
      state_d = ST_INIT;
    end else begin
      unique case (state_q)
        ST_WARMUP: begin
          if (ce) begin
            s_d    = s_step;
            step_d = step_q + STEP_W'(1);
            warm_d = warm_q + WARM_W'(1);
            if (warm_q == WARM_W'(WARMUP - 1)) state_d = ST_RUN;
          end
        end
        default: begin
          if (ce && (!valid_q || out_ready)) begin
            s_d     = s_step;
            step_d  = step_q + STEP_W'(1);
            valid_d = 1'b1;
            data_d  = fold_word(s_step);
          end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
          end
        end
      endcase
    end
    busy_d = (state_d == ST_WARMUP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      s_q     <= SEED;
      step_q  <= '0;
      warm_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= (ST_INIT == ST_WARMUP);
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      step_q  <= step_d;
      warm_q  <= warm_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign busy      = busy_q;

`ifdef CA_PRNG_HEALTH_EN
  logic [WIDTH-1:0] last_q, last_d;
  logic [2:0]       rep_q, rep_d;
  logic             fail_q, fail_d;

  // rep_q counts the current run of equal delivered words (0 = nothing delivered yet).
  always_comb begin
    last_d = last_q;
    rep_d  = rep_q;
    fail_d = fail_q;
    if (seed_valid) begin
      rep_d  = 3'd0;
      fail_d = 1'b0;
    end else if (valid_q && out_ready) begin
      last_d = data_q;
      if ((rep_q != 3'd0) && (data_q == last_q)) begin
        if (rep_q != 3'd4) rep_d = rep_q + 3'd1;
      end else begin
        rep_d = 3'd1;
      end
      if (rep_d == 3'd4) fail_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= '0;
      rep_q  <= 3'd0;
      fail_q <= 1'b0;
    end else begin
      last_q <= last_d;
      rep_q  <= rep_d;
      fail_q <= fail_d;
    end
  end

  assign health_fail = fail_q;
`endif

endmodule

// File: tb/tb_ca_prng_stream.sv
// Directed bench for ca_prng_stream: WIDTH=4, PARITY_WIDTH=3, SEED=12'h040, WARMUP 16 and 0 instances.
module tb_ca_prng_stream;

  logic       clk;
  logic       rst_n;
  logic       ce;
  logic [1:0] mode;
  logic [7:0] rule_in;
  logic       seed_valid;
  logic [3:0] seed;
  logic       out_ready;

  logic       w_valid, w_busy, z_valid, z_busy;
  logic [3:0] w_data, z_data;
`ifdef CA_PRNG_HEALTH_EN
  logic       w_hf, z_hf;
`endif

  int errors;
  int checks;

  logic [11:0] ms;
  logic [15:0] mstep;
  logic [3:0]  held;

  ca_prng_stream #(.WIDTH(4), .PARITY_WIDTH(3), .SEED(12'h040), .WARMUP(16), .RULE_SHIFT(1)) u_w (
    .clk(clk), .rst_n(rst_n), .ce(ce), .mode(mode), .rule_in(rule_in),
    .seed_valid(seed_valid), .seed(seed), .out_valid(w_valid), .out_ready(out_ready),
    .out_data(w_data),
`ifdef CA_PRNG_HEALTH_EN
    .health_fail(w_hf),
`endif
    .busy(w_busy)
  );

  ca_prng_stream #(.WIDTH(4), .PARITY_WIDTH(3), .SEED(12'h040), .WARMUP(0), .RULE_SHIFT(1)) u_z (
    .clk(clk), .rst_n(rst_n), .ce(ce), .mode(mode), .rule_in(rule_in),
    .seed_valid(seed_valid), .seed(seed), .out_valid(z_valid), .out_ready(out_ready),
    .out_data(z_data),
`ifdef CA_PRNG_HEALTH_EN
    .health_fail(z_hf),
`endif
    .busy(z_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference CA step straight from the neighbourhood definition, with zero guard.
  function automatic logic [11:0] ca_step(input logic [11:0] s, input logic [7:0] r);
    logic [11:0] n;
    int          l, c, rr;
    for (int i = 0; i < 12; i++) begin
      l    = int'(s[(i + 1) % 12]);
      c    = int'(s[i]);
      rr   = int'(s[(i + 11) % 12]);
      n[i] = r[l * 4 + c * 2 + rr];
    end
    if (n == 12'h000) n = 12'h040;
    return n;
  endfunction

  function automatic logic [3:0] fold(input logic [11:0] s);
    logic [3:0] o;
    logic [2:0] g;
    for (int i = 0; i < 4; i++) begin
      g    = s[i*3 +: 3];
      o[i] = (i % 2 == 1) ? ^g : ~^g;
    end
    return o;
  endfunction

  function automatic logic [7:0] rule_of(input logic [1:0] m, input logic [7:0] r, input logic [15:0] sc);
    logic [1:0] k;
    k = sc[2:1];
    case (m)
      2'd0: return 8'h1E;
      2'd1: return (k == 2'd0) ? 8'h1E : (k == 2'd1) ? 8'h3C : (k == 2'd2) ? 8'h5A : 8'h96;
      2'd2: return r;
      default: return 8'h96;
    endcase
  endfunction

  // One delivered word on the WARMUP=0 instance, predicted by the model.
  task automatic step_word(input string tag);
    ms = ca_step(ms, rule_of(mode, rule_in, mstep));
    mstep++;
    tick();
    check({tag, "_valid"}, 16'(z_valid), 16'd1);
    check(tag, 16'(z_data), 16'(fold(ms)));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0; ce = 1'b0; mode = 2'd2; rule_in = 8'hCC;
    seed_valid = 1'b0; seed = 4'h0; out_ready = 1'b1;
    ms = 12'h040; mstep = 16'd0; held = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_w_busy", 16'(w_busy), 16'd1);
    check("rst_w_valid", 16'(w_valid), 16'd0);
    check("rst_w_data", 16'(w_data), 16'd0);
    check("rst_z_busy", 16'(z_busy), 16'd0);
    check("rst_z_valid", 16'(z_valid), 16'd0);
    check("rst_z_data", 16'(z_data), 16'd0);
`ifdef CA_PRNG_HEALTH_EN
    check("rst_z_health", 16'(z_hf), 16'd0);
`endif

    // Warm-up on u_w while u_z streams the identity rule from reset.
    rst_n = 1'b1;
    ce    = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("warm_busy", 16'(w_busy), 16'd1);
      check("warm_valid", 16'(w_valid), 16'd0);
      if (i >= 1) check("ident_data", 16'(z_data), 16'b0001);
`ifdef CA_PRNG_HEALTH_EN
      if (i == 4) check("health_before4", 16'(z_hf), 16'd0);
      if (i == 5) check("health_after4", 16'(z_hf), 16'd1);
`endif
      tick();
    end
    check("warm_done_busy", 16'(w_busy), 16'd0);
    check("warm_done_valid", 16'(w_valid), 16'd0);
    tick();
    check("warm_first_valid", 16'(w_valid), 16'd1);
    check("warm_first_data", 16'(w_data), 16'b0001);

    // Rule 0 collapses the CA; the guard must reload SEED each step.
    rule_in = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("zero_rule_data", 16'(z_data), 16'b0001);
    end
    rule_in = 8'hCC;
    tick();
    tick();
    check("guard_state_data", 16'(z_data), 16'b0001);

    // Reseed mid-stream.
    seed       = 4'hF;
    seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
    check("reseed_z_valid", 16'(z_valid), 16'd0);
    check("reseed_z_busy", 16'(z_busy), 16'd0);
    check("reseed_w_busy", 16'(w_busy), 16'd1);
    check("reseed_w_valid", 16'(w_valid), 16'd0);
`ifdef CA_PRNG_HEALTH_EN
    check("reseed_health", 16'(z_hf), 16'd0);
`endif
    ms    = 12'hFBF;
    mstep = 16'd0;
    tick();
    mstep++;
    check("reseed_word_valid", 16'(z_valid), 16'd1);
    check("reseed_word", 16'(z_data), 16'b1110);

    // Rule 150: FBF -> F1F, folded to 1000.
    mode = 2'd3;
    step_word("r150_a");
    check("r150_hand", 16'(z_data), 16'b1000);
    step_word("r150_b");
    step_word("r150_c");

    // Scheduled rules with a 5-cycle backpressure hold in the middle.
    mode = 2'd1;
    step_word("sched_a");
    step_word("sched_b");
    step_word("sched_c");
    held      = z_data;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", 16'(z_valid), 16'd1);
      check("hold_data", 16'(z_data), 16'(held));
    end
    out_ready = 1'b1;
    #1;
    check("hold_release_data", 16'(z_data), 16'(held));
    step_word("sched_d");
    step_word("sched_e");
    step_word("sched_f");
    step_word("sched_g");

    // Rule 30, then consumption while ce is low.
    mode = 2'd0;
    step_word("r30_a");
    step_word("r30_b");
    ce = 1'b0;
    tick();
    check("ce0_consume_valid", 16'(z_valid), 16'd0);
    tick();
    check("ce0_idle_valid", 16'(z_valid), 16'd0);
    ce = 1'b1;
    step_word("r30_resume");

    // Asynchronous reset between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_z_valid", 16'(z_valid), 16'd0);
    check("async_z_data", 16'(z_data), 16'd0);
    check("async_w_busy", 16'(w_busy), 16'd1);
    check("async_z_busy", 16'(z_busy), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
